// File: rtl/spi_flash_id_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_id_responder
// Purpose  : SPI mode-0 slave emulating the W25Qxx ID-read commands
//            (0x90, 0x9F, 0xAB), with all SPI pins oversampled on clk.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_id_responder #(
  parameter logic [7:0] MF_ID    = 8'hEF,
  parameter logic [7:0] DEV_ID   = 8'h17,
  parameter logic [7:0] MEM_TYPE = 8'h40,
  parameter logic [7:0] CAPACITY = 8'h18
) (
  input  logic       rstn,
  input  logic       clk,
  input  logic       spi_ss,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       cmd_valid,
  output logic [7:0] cmd
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [7:0] CMD_MFDEV = 8'h90;
  localparam logic [7:0] CMD_JEDEC = 8'h9F;
  localparam logic [7:0] CMD_RDID  = 8'hAB;

  logic       r_ss_s1;
  logic       r_ss_s2;
  logic       r_sck_s1;
  logic       r_sck_s2;
  logic       r_sck_d;
  logic       r_mosi_s1;
  logic       r_mosi_s2;
  logic [1:0] r_flush;
  logic       r_armed;

  logic [1:0] r_state;
  logic [2:0] r_bit_idx;
  logic [2:0] r_byte_idx;
  logic [6:0] r_rx;
  logic       r_a0;
  logic [7:0] r_cmd;
  logic       r_cmd_valid;
  logic       r_miso;
  logic       r_oe;

  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_active;
  logic [7:0] w_rx_next;
  logic [2:0] w_byte_next;
  logic [2:0] w_bit_sel;
  logic [7:0] w_resp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_d   <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_flush   <= 2'b00;
    end else begin
      r_ss_s1   <= spi_ss;
      r_ss_s2   <= r_ss_s1;
      r_sck_s1  <= spi_sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_flush   <= {r_flush[0], 1'b1};
    end
  end

  // The synchronizer comes out of reset reading ss=1; only trust a high
  // level once real pin samples have flushed through, or a frame that
  // straddles reset would be accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_armed <= 1'b0;
    end else if (r_flush[1] && r_ss_s2) begin
      r_armed <= 1'b1;
    end
  end

  assign w_sck_rise  = r_sck_s2 & ~r_sck_d;
  assign w_sck_fall  = ~r_sck_s2 & r_sck_d;
  assign w_active    = r_armed & ~r_ss_s2;
  assign w_rx_next   = {r_rx, r_mosi_s2};
  assign w_byte_next = (r_byte_idx == 3'd7) ? 3'd4 : (r_byte_idx + 3'd1);
  assign w_bit_sel   = 3'd7 - r_bit_idx;

  // Past byte 3 only byte_idx parity matters, hence the 7->4 wrap.
  always_comb begin
    w_resp = 8'h00;
    if (r_state == ST_DATA) begin
      case (r_cmd)
        CMD_MFDEV: begin
          if (r_byte_idx >= 3'd4) begin
            w_resp = (r_byte_idx[0] == r_a0) ? MF_ID : DEV_ID;
          end
        end
        CMD_JEDEC: begin
          case (r_byte_idx)
            3'd1:    w_resp = MF_ID;
            3'd2:    w_resp = MEM_TYPE;
            3'd3:    w_resp = CAPACITY;
            default: w_resp = 8'h00;
          endcase
        end
        CMD_RDID: begin
          if (r_byte_idx >= 3'd4) begin
            w_resp = DEV_ID;
          end
        end
        default: w_resp = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_bit_idx   <= 3'd0;
      r_byte_idx  <= 3'd0;
      r_rx        <= 7'd0;
      r_a0        <= 1'b0;
      r_cmd       <= 8'h00;
      r_cmd_valid <= 1'b0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_oe        <= w_active;
      if (!w_active) begin
        r_state    <= ST_IDLE;
        r_bit_idx  <= 3'd0;
        r_byte_idx <= 3'd0;
        r_rx       <= 7'd0;
        r_miso     <= 1'b0;
      end else begin
        if (r_state == ST_IDLE) begin
          r_state <= ST_CMD;
        end
        if (w_sck_rise) begin
          r_rx      <= w_rx_next[6:0];
          r_bit_idx <= r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            r_byte_idx <= w_byte_next;
            if (r_byte_idx == 3'd0) begin
              r_cmd       <= w_rx_next;
              r_cmd_valid <= 1'b1;
              r_state     <= ST_DATA;
            end
            if ((r_byte_idx == 3'd3) && (r_cmd == CMD_MFDEV)) begin
              r_a0 <= r_mosi_s2;
            end
          end
        end else if (w_sck_fall) begin
          r_miso <= w_resp[w_bit_sel];
        end
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_oe;
  assign cmd_valid   = r_cmd_valid;
  assign cmd         = r_cmd;

endmodule
`default_nettype wire
